// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle for alu_seq: valid/ready in, valid/ready out.
// The ALU uses the slave modport; the producer/consumer side uses master.
interface alu_seq_if #(
    parameter int unsigned WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [2:0]       f;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] xy;
    logic             c;
    logic             z;

    modport slave (
        input  in_valid, x, y, f, out_ready,
        output in_ready, out_valid, xy, c, z
    );

    modport master (
        output in_valid, x, y, f, out_ready,
        input  in_ready, out_valid, xy, c, z
    );
endinterface

// File: rtl/alu_seq.sv
// Handshaked X/Y/F ALU with registered result, carry/zero flags and shift-add multiplier.
// Optional saturation of ADD/SUB/MUL is enabled by defining ALU_SEQ_SAT_EN.
module alu_seq #(
    parameter int unsigned WIDTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_seq_if.slave   bus
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_MUL2 = 3'd2;
    localparam logic [2:0] OP_MUL  = 3'd4;

    logic [1:0]         state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   xy_q, xy_d;
    logic               c_q, c_d;
    logic               z_q, z_d;

    logic [WIDTH:0]     wide;
    logic [WIDTH-1:0]   alu_xy;
    logic               alu_c;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     step_sum;
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH-1:0]   mul_xy;
    logic               mul_c;

    // Single-cycle ops, evaluated straight off the bus in the accepting cycle.
    always_comb begin
        wide   = '0;
        alu_xy = '0;
        alu_c  = 1'b0;
        case (bus.f)
            OP_ADD: begin
                wide   = {1'b0, bus.x} + {1'b0, bus.y};
                alu_xy = wide[WIDTH-1:0];
                alu_c  = wide[WIDTH];
`ifdef ALU_SEQ_SAT_EN
                if (alu_c) alu_xy = '1;
`endif
            end
            OP_SUB: begin
                wide   = {1'b0, bus.x} - {1'b0, bus.y};
                alu_xy = wide[WIDTH-1:0];
                alu_c  = wide[WIDTH];
`ifdef ALU_SEQ_SAT_EN
                if (alu_c) alu_xy = '0;
`endif
            end
            OP_MUL2: begin
                alu_xy = {bus.x[WIDTH-2:0], 1'b0};
                alu_c  = bus.x[WIDTH-1];
            end
            default: begin
                alu_xy = '0;
                alu_c  = 1'b0;
            end
        endcase
    end

    // One shift-add step: multiplier sits in the low half and shifts out LSB first.
    always_comb begin
        addend   = acc_q[0] ? mcand_q : {WIDTH{1'b0}};
        step_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        acc_step = {step_sum, acc_q[WIDTH-1:1]};
        mul_c    = |acc_step[2*WIDTH-1:WIDTH];
        mul_xy   = acc_step[WIDTH-1:0];
`ifdef ALU_SEQ_SAT_EN
        if (mul_c) mul_xy = '1;
`endif
    end

    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        xy_d    = xy_q;
        c_d     = c_q;
        z_d     = z_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    if (bus.f == OP_MUL) begin
                        mcand_d = bus.x;
                        acc_d   = {{WIDTH{1'b0}}, bus.y};
                        cnt_d   = CW'(WIDTH);
                        state_d = MUL;
                    end else begin
                        xy_d    = alu_xy;
                        c_d     = alu_c;
                        z_d     = (alu_xy == '0);
                        state_d = DONE;
                    end
                end
            end
            MUL: begin
                acc_d = acc_step;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    xy_d    = mul_xy;
                    c_d     = mul_c;
                    z_d     = (mul_xy == '0);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mcand_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            xy_q    <= '0;
            c_q     <= 1'b0;
            z_q     <= 1'b1;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            xy_q    <= xy_d;
            c_q     <= c_d;
            z_q     <= z_d;
        end
    end

    // Gate with rst_n so the block never advertises ready while held in reset.
    assign bus.in_ready  = (state_q == IDLE) && rst_n;
    assign bus.out_valid = (state_q == DONE);
    assign bus.xy        = xy_q;
    assign bus.c         = c_q;
    assign bus.z         = z_q;
endmodule

// File: tb/tb_alu_seq.sv
// Directed scoreboard bench for alu_seq at WIDTH=4; honours ALU_SEQ_SAT_EN if defined.
module tb_alu_seq;
    localparam int W = 4;
    localparam int M = 1 << W;

    typedef struct packed {
        logic [W-1:0] xy;
        logic         c;
        logic         z;
    } res_t;

    logic clk;
    logic rst_n;
    res_t sb[$];
    int   n_tests;
    int   n_fail;

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic res_t model(input int x, input int y, input int f);
        res_t r;
        int   v;
        logic cc;
        v  = 0;
        cc = 1'b0;
        case (f)
            0: begin
                v  = x + y;
                cc = (v >= M);
                v  = v % M;
`ifdef ALU_SEQ_SAT_EN
                if (cc) v = M - 1;
`endif
            end
            1: begin
                cc = (x < y);
                v  = (x - y + M) % M;
`ifdef ALU_SEQ_SAT_EN
                if (cc) v = 0;
`endif
            end
            2: begin
                cc = (x >= M / 2);
                v  = (2 * x) % M;
            end
            4: begin
                v  = x * y;
                cc = (v >= M);
                v  = v % M;
`ifdef ALU_SEQ_SAT_EN
                if (cc) v = M - 1;
`endif
            end
            default: begin
                v  = 0;
                cc = 1'b0;
            end
        endcase
        r.xy = v[W-1:0];
        r.c  = cc;
        r.z  = (v == 0);
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an op once in_ready is seen, then scramble operands after acceptance.
    task automatic send(input int x, input int y, input int f);
        int guard;
        guard = 0;
        while (bus.in_ready !== 1'b1 && guard < 50) begin
            tick();
            guard++;
        end
        check("in_ready_wait", 32'(guard < 50), 32'd1);
        bus.in_valid = 1'b1;
        bus.x        = W'(x);
        bus.y        = W'(y);
        bus.f        = 3'(f);
        sb.push_back(model(x, y, f));
        tick();
        bus.in_valid = 1'b0;
        bus.x        = W'($urandom);
        bus.y        = W'($urandom);
        bus.f        = 3'($urandom);
    endtask

    // Called right after send(); counts edges since acceptance, then checks and drains.
    task automatic receive(input string tag, input int lat_exp);
        int   lat;
        res_t e;
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(lat_exp));
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        check({tag, "_xy"}, 32'(bus.xy), 32'(e.xy));
        check({tag, "_c"}, 32'(bus.c), 32'(e.c));
        check({tag, "_z"}, 32'(bus.z), 32'(e.z));
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({tag, "_drain"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        int seen;
        n_tests       = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.x         = '0;
        bus.y         = '0;
        bus.f         = '0;
        tick();
        tick();
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_xy", 32'(bus.xy), 32'd0);
        check("rst_c", 32'(bus.c), 32'd0);
        check("rst_z", 32'(bus.z), 32'd1);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready", 32'(bus.in_ready), 32'd1);

        send(9, 8, 0);  receive("add_9_8", 1);
        send(3, 5, 1);  receive("sub_3_5", 1);
        send(7, 3, 1);  receive("sub_7_3", 1);
        send(9, 0, 2);  receive("mul2_9", 1);
        send(5, 0, 2);  receive("mul2_5", 1);
        send(7, 3, 4);  receive("mul_7_3", W + 1);
        send(3, 5, 4);  receive("mul_3_5", W + 1);
        send(0, 9, 4);  receive("mul_0_9", W + 1);
        send(15, 15, 4); receive("mul_15_15", W + 1);
        send(5, 5, 6);  receive("rsv_6", 1);
        send(5, 5, 3);  receive("zero_3", 1);
        send(8, 8, 0);  receive("add_8_8", 1);

        for (int i = 0; i < 8; i++) begin
            int rx, ry, rf;
            rx = int'($urandom_range(M - 1, 0));
            ry = int'($urandom_range(M - 1, 0));
            rf = int'($urandom_range(7, 0));
            send(rx, ry, rf);
            receive("rand", (rf == 4) ? W + 1 : 1);
        end

        // Backpressure: new operands offered while the result is held must be ignored.
        send(2, 2, 0);
        check("bp_valid", 32'(bus.out_valid), 32'd1);
        bus.in_valid = 1'b1;
        bus.x        = W'(7);
        bus.y        = W'(1);
        bus.f        = 3'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_xy", 32'(bus.xy), 32'd4);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
        end
        begin
            res_t e;
            e = (sb.size() > 0) ? sb.pop_front() : '0;
            check("bp_result", 32'(bus.xy), 32'(e.xy));
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("bp_idle_ready", 32'(bus.in_ready), 32'd1);
        check("bp_idle_valid", 32'(bus.out_valid), 32'd0);
        sb.push_back(model(7, 1, 0));
        tick();
        bus.in_valid = 1'b0;
        receive("bp_new_op", 1);

        // Asynchronous reset two edges into a multiply.
        send(15, 15, 4);
        void'(sb.pop_back());
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_out_valid", 32'(bus.out_valid), 32'd0);
        check("ar_xy", 32'(bus.xy), 32'd0);
        check("ar_z", 32'(bus.z), 32'd1);
        check("ar_in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        check("ar_rel_ready", 32'(bus.in_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 2 * W + 4; i++) begin
            tick();
            if (bus.out_valid === 1'b1) seen++;
        end
        check("ar_no_stale", 32'(seen), 32'd0);
        send(3, 5, 4);  receive("post_rst_mul", W + 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
